// File: rtl/single_argmax_seq.sv
// single_argmax_seq: streams LEN fp32 elements through one registered single_max comparator
// and returns the maximum value and the index of its first occurrence. Macro SINGLE_ARGMAX_LAST_EN adds early end on in_last.

module single_max (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_c
);
    logic        w_b_gt;
    logic [31:0] r_c;

    // Negative values order by decreasing magnitude; this also puts +0 above -0.
    always_comb begin
        if (i_a[31] != i_b[31]) w_b_gt = i_a[31];
        else if (i_a[31])       w_b_gt = (i_b[30:0] < i_a[30:0]);
        else                    w_b_gt = (i_b[30:0] > i_a[30:0]);
    end

    always_ff @(posedge clk) begin
        if (!rstn) r_c <= '0;
        else       r_c <= w_b_gt ? i_b : i_a;
    end

    assign o_c = r_c;
endmodule

// state | meaning
// IDLE  | waiting for the first element of a vector
// RUN   | waiting for the next element, comparator fed with r_max and in_data
// WAIT  | comparator result valid, fold it into r_max / r_idx
// DONE  | result presented until out_ready
module single_argmax_seq #(
    parameter int LEN  = 16,
    parameter int IDXW = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_max,
    output logic [IDXW-1:0] out_idx,
    output logic            busy
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

    localparam logic          ONE_ELEM = (LEN == 1);
    localparam logic [IDXW:0] CNT_ONE  = (IDXW+1)'(1);
    localparam logic [IDXW:0] CNT_LAST = (IDXW+1)'(LEN - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_alive;
    logic [31:0]     r_max;
    logic [IDXW-1:0] r_idx;
    logic [31:0]     r_cand;
    logic [IDXW-1:0] r_cand_idx;
    logic [IDXW:0]   r_cnt;
    logic [31:0]     w_cmp;
    logic            w_hs;
    logic            w_ld_first;
    logic            w_ld_cand;
    logic            w_upd;
    logic            w_in_end;
    logic            w_wait_end;

    single_max u_max (
        .clk  (clk),
        .rstn (rstn),
        .i_a  (r_max),
        .i_b  (in_data),
        .o_c  (w_cmp)
    );

    // r_alive keeps in_ready low through reset without a combinational path from rstn.
    assign in_ready  = r_alive && ((r_state == S_IDLE) || (r_state == S_RUN));
    assign out_valid = (r_state == S_DONE);
    assign out_max   = out_valid ? r_max : '0;
    assign out_idx   = out_valid ? r_idx : '0;
    assign busy      = (r_state != S_IDLE);
    assign w_hs      = in_valid && in_ready;

`ifdef SINGLE_ARGMAX_LAST_EN
    logic r_cand_last;

    assign w_in_end   = in_last;
    assign w_wait_end = (r_cnt == CNT_LAST) || r_cand_last;

    always_ff @(posedge clk) begin
        if (!rstn)          r_cand_last <= 1'b0;
        else if (w_ld_cand) r_cand_last <= in_last;
    end
`else
    logic w_unused_last;

    assign w_in_end      = 1'b0;
    assign w_wait_end    = (r_cnt == CNT_LAST);
    assign w_unused_last = in_last;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld_first  = 1'b0;
        w_ld_cand   = 1'b0;
        w_upd       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_ld_first  = 1'b1;
                    w_state_nxt = (ONE_ELEM || w_in_end) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_hs) begin
                    w_ld_cand   = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_upd       = 1'b1;
                w_state_nxt = w_wait_end ? S_DONE : S_RUN;
            end
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // In WAIT r_cnt still equals r_cand_idx, so the terminal-count compare marks the last element.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_max      <= '0;
            r_idx      <= '0;
            r_cand     <= '0;
            r_cand_idx <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_ld_first) begin
                r_max <= in_data;
                r_idx <= '0;
                r_cnt <= CNT_ONE;
            end
            if (w_ld_cand) begin
                r_cand     <= in_data;
                r_cand_idx <= r_cnt[IDXW-1:0];
            end
            if (w_upd) begin
                r_max <= w_cmp;
                if ((w_cmp == r_cand) && (r_cand != r_max)) r_idx <= r_cand_idx;
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_single_argmax_seq.sv
// Bench for single_argmax_seq: directed vectors with literal results plus a randomized stream
// checked every cycle against an order-key argmax model.
`timescale 1ns/1ps
module tb_single_argmax_seq;
    localparam int LEN  = 4;
    localparam int IDXW = 2;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic [31:0]     in_data = '0;
    logic            dir_ready = 1'b1;
    logic            rand_bp = 1'b0;
    logic            r_bp = 1'b1;
    logic            out_ready;
    logic            in_ready, out_valid, busy;
    logic [31:0]     out_max;
    logic [IDXW-1:0] out_idx;

    logic            v1_in_valid = 1'b0;
    logic [31:0]     v1_in_data = '0;
    logic            v1_out_ready = 1'b1;
    logic            v1_in_ready, v1_out_valid, v1_busy;
    logic [31:0]     v1_out_max;
    logic [0:0]      v1_out_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic rst_edge = 1'b1;

    assign out_ready = rand_bp ? r_bp : dir_ready;

    single_argmax_seq #(.LEN(LEN)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
        .out_idx(out_idx), .busy(busy)
    );

    single_argmax_seq #(.LEN(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .in_valid(v1_in_valid), .in_ready(v1_in_ready), .in_data(v1_in_data),
        .in_last(1'b0), .out_valid(v1_out_valid), .out_ready(v1_out_ready), .out_max(v1_out_max),
        .out_idx(v1_out_idx), .busy(v1_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= !rstn;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monotone key: unsigned order of keys equals the float ordering with -0 below +0.
    function automatic logic [31:0] fkey(input logic [31:0] b);
        return b[31] ? ~b : (b | 32'h8000_0000);
    endfunction

    // ---------------- reference model and per-cycle compare ----------------
    logic [31:0] q_max[$];
    int          q_idx[$];
    int          m_n = 0;
    logic [31:0] m_best = '0;
    int          m_bi = 0;
    bit          m_wait = 0, m_pend = 0, m_outv = 0;
    logic [31:0] m_last_max = '0;
    int          m_last_idx = 0;

    always @(negedge clk) begin
        bit er, eb, hs, last, first;
        if (rst_edge) begin
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_out_max", out_max, 32'd0);
            chk("rst_out_idx", 32'(out_idx), 32'd0);
            m_n = 0; m_wait = 0; m_pend = 0; m_outv = 0;
            q_max.delete(); q_idx.delete();
        end else begin
            er = !m_outv && !m_wait;
            eb = m_outv || m_wait || m_pend || (m_n != 0);
            chk("in_ready", 32'(in_ready), 32'(er));
            chk("out_valid", 32'(out_valid), 32'(m_outv));
            chk("busy", 32'(busy), 32'(eb));
            if (m_outv) begin
                chk("pending_result", 32'(q_max.size() != 0), 32'd1);
                if (q_max.size() != 0) begin
                    chk("out_max", out_max, q_max[0]);
                    chk("out_idx", 32'(out_idx), 32'(q_idx[0]));
                end
                if (out_ready) begin
                    if (q_max.size() != 0) begin
                        void'(q_max.pop_front());
                        void'(q_idx.pop_front());
                    end
                    m_outv = 0;
                end
            end
            m_wait = 0;
            if (m_pend) begin m_outv = 1; m_pend = 0; end
            hs = in_valid && er && rstn;
            if (hs) begin
                first = (m_n == 0);
                if (first) begin
                    m_best = in_data; m_bi = 0;
                end else begin
                    m_wait = 1;
                    if (fkey(in_data) > fkey(m_best)) begin m_best = in_data; m_bi = m_n; end
                end
                m_n++;
                last = (m_n == LEN);
`ifdef SINGLE_ARGMAX_LAST_EN
                if (in_last) last = 1;
`endif
                if (last) begin
                    q_max.push_back(m_best); q_idx.push_back(m_bi);
                    m_last_max = m_best; m_last_idx = m_bi;
                    m_n = 0;
                    if (first) m_outv = 1; else m_pend = 1;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        r_bp = ($urandom_range(0, 2) != 0);
    end

    // ---------------- driver ----------------
    task automatic push(input logic [31:0] d, input logic lst, output int c_hs);
        int w = 0;
        in_valid = 1'b1; in_data = d; in_last = lst;
        while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
        chk("push_wait_bound", 32'(w < 200), 32'd1);
        @(posedge clk); #1;
        c_hs = cyc;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_out(output int c_seen);
        int w = 0;
        while (!out_valid && w < 200) begin @(posedge clk); #1; w++; end
        chk("out_wait_bound", 32'(w < 200), 32'd1);
        c_seen = cyc;
    endtask

    task automatic send_vec(input logic [31:0] v[LEN], input int gap_after, input int ngaps, output int c0);
        int c;
        c0 = 0;
        for (int i = 0; i < LEN; i++) begin
            push(v[i], 1'b0, c);
            if (i == 0) c0 = c;
            if (i == gap_after) repeat (ngaps) begin @(posedge clk); #1; end
        end
    endtask

    task automatic pass_out();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] vec[LEN];
        int c0, c1, c, w;
        #300_000;
        $display("FAIL watchdog: actual timeout, required completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [31:0] vec[LEN];
        int c0, c1, c, w;
        repeat (3) @(posedge clk);
        #1; rstn = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_release", 32'(in_ready), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);

        // ascending, back-to-back, latency 2*LEN-1 cycles from the first handshake
        vec = '{32'hBF80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h4000_0000};
        send_vec(vec, -1, 0, c0);
        wait_out(c1);
        chk("asc_latency", 32'(c1 - c0 + 1), 32'd7);
        chk("asc_max", out_max, 32'h4000_0000);
        chk("asc_idx", 32'(out_idx), 32'd3);
        chk("model_asc_max", m_last_max, 32'h4000_0000);
        chk("model_asc_idx", 32'(m_last_idx), 32'd3);
        pass_out();

        // +0 must not displace 3.0 held at index 0
        vec = '{32'h4040_0000, 32'hC000_0000, 32'h8000_0000, 32'h0000_0000};
        send_vec(vec, -1, 0, c0);
        wait_out(c1);
        chk("szero_max", out_max, 32'h4040_0000);
        chk("szero_idx", 32'(out_idx), 32'd0);
        chk("model_szero_idx", 32'(m_last_idx), 32'd0);
        pass_out();

        vec = '{32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h3F80_0000};
        send_vec(vec, -1, 0, c0);
        wait_out(c1);
        chk("tie_max", out_max, 32'h4000_0000);
        chk("tie_idx", 32'(out_idx), 32'd1);
        pass_out();

        // LEN=1 instance: result on the cycle after the only handshake
        v1_in_data = 32'hC000_0000; v1_in_valid = 1'b1;
        w = 0;
        while (!v1_in_ready && w < 50) begin @(posedge clk); #1; w++; end
        chk("len1_wait_bound", 32'(w < 50), 32'd1);
        @(posedge clk); #1;
        v1_in_valid = 1'b0;
        chk("len1_valid", 32'(v1_out_valid), 32'd1);
        chk("len1_max", v1_out_max, 32'hC000_0000);
        chk("len1_idx", 32'(v1_out_idx), 32'd0);
        chk("len1_busy", 32'(v1_busy), 32'd1);
        @(posedge clk); #1;
        chk("len1_consumed", 32'(v1_out_valid), 32'd0);
        chk("len1_ready_again", 32'(v1_in_ready), 32'd1);

        // backpressure: result held 5 cycles, no input accepted
        dir_ready = 1'b0;
        send_vec(vec, -1, 0, c0);
        wait_out(c1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_max", out_max, 32'h4000_0000);
            chk("bp_idx", 32'(out_idx), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        dir_ready = 1'b1;
        pass_out();
        chk("bp_release", 32'(out_valid), 32'd0);

        // stall mid-vector gives the same answer
        vec = '{32'hBF80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h4000_0000};
        send_vec(vec, 1, 3, c0);
        wait_out(c1);
        chk("gap_max", out_max, 32'h4000_0000);
        chk("gap_idx", 32'(out_idx), 32'd3);
        pass_out();

        // reset after 2 of 4 elements discards the partial vector
        push(32'h3F80_0000, 1'b0, c);
        push(32'h7F00_0000, 1'b0, c);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("rst_no_out", 32'(out_valid), 32'd0);
        end
        vec = '{32'hBF80_0000, 32'hC000_0000, 32'hBF80_0000, 32'hC040_0000};
        send_vec(vec, -1, 0, c0);
        wait_out(c1);
        chk("post_rst_max", out_max, 32'hBF80_0000);
        chk("post_rst_idx", 32'(out_idx), 32'd0);
        pass_out();

`ifdef SINGLE_ARGMAX_LAST_EN
        push(32'h3F80_0000, 1'b0, c0);
        push(32'h4040_0000, 1'b0, c);
        push(32'h4000_0000, 1'b1, c);
        wait_out(c1);
        chk("early_max", out_max, 32'h4040_0000);
        chk("early_idx", 32'(out_idx), 32'd1);
        pass_out();
        push(32'hC000_0000, 1'b1, c0);
        chk("early_first_valid", 32'(out_valid), 32'd1);
        chk("early_first_max", out_max, 32'hC000_0000);
        pass_out();
`endif

        // randomized stream with random gaps, in_last and output backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 60 * LEN; i++) begin
            logic [31:0] d;
            case ($urandom_range(0, 7))
                0: d = 32'h0000_0000;
                1: d = 32'h8000_0000;
                2: d = 32'h3F80_0000;
                3: d = 32'hBF80_0000;
                4: d = 32'h7F80_0000;
                5: d = 32'hFF80_0000;
                default: d = $urandom();
            endcase
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            push(d, ($urandom_range(0, 5) == 0), c);
        end
`ifdef SINGLE_ARGMAX_LAST_EN
        push(32'h0000_0001, 1'b1, c);
`endif
        repeat (20) begin @(posedge clk); #1; end
        rand_bp = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        chk("drain_queue_empty", 32'(q_max.size()), 32'd0);
        chk("drain_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/single_argmax_seq.md
# single_argmax_seq

Sequencer that streams a vector of IEEE-754 single-precision values through one internal `single_max` comparator. It returns the maximum value and the index of its first occurrence. The block sits after a dense or convolution layer output in the network datapath and feeds classification and max-pool stages. It owns the comparator's 1-cycle registered latency, so requesters only see a valid/ready stream in and a valid/ready result out.

## Interface
Parameters:
- `LEN`, default 16: elements per vector; must be ≥ 1.
- `IDXW`, default `$clog2(LEN)` (minimum 1): width of the index output.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low; clock `clk`.
- `in_valid` in 1: input element valid.
- `in_ready` out 1: block can accept an element.
- `in_data` in 32: single-precision element.
- `in_last` in 1: last element of the vector. Used only with `SINGLE_ARGMAX_LAST_EN`; ignored otherwise.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_max` out 32: maximum value.
- `out_idx` out IDXW: index of the maximum, 0-based.
- `busy` out 1: asserted in every state except IDLE.

## Operation
- An internal `single_max` instance provides the ordering: sign bit first, then exponent, then mantissa, with 1 cycle of registered latency.
  - +0 is greater than −0.
  - NaN and Inf get no special handling; they are ordered by their bit pattern under the same rule.
- Internal registers:
  - `max_r` (32 bits) and `idx_r` (IDXW bits).
  - `cand_r` and `cand_idx_r`: the element under comparison and its index.
  - `cnt` (IDXW+1 bits): number of elements accepted.
- A handshake happens on `in_valid && in_ready`.
- FSM states: IDLE, RUN, WAIT, DONE.
  - **IDLE**: `in_ready` = 1. On handshake: `max_r` ← `in_data`, `idx_r` ← 0, `cnt` ← 1. If this was the last element go to DONE, otherwise go to RUN.
  - **RUN**: `in_ready` = 1. Comparator inputs are `a` = `max_r`, `b` = `in_data`. On handshake: `cand_r` ← `in_data`, `cand_idx_r` ← `cnt`, go to WAIT.
  - **WAIT**: `in_ready` = 0. Comparator output `c` is valid in this state.
    - `max_r` ← `c`.
    - If `c == cand_r && cand_r != max_r`, then `idx_r` ← `cand_idx_r`.
    - `cnt` ← `cnt` + 1.
    - If `cand_idx_r` was the last element, go to DONE; otherwise go to RUN.
  - **DONE**: `out_valid` = 1, `out_max` = `max_r`, `out_idx` = `idx_r`. On `out_ready`, go to IDLE.
- Ties (bit-identical values) keep the earlier index. This follows from the strict-update rule in WAIT.
- The last element is the one with index `LEN`−1.
- While `in_valid` = 0 in RUN, the block stalls and all registers hold.
- `out_max` and `out_idx` hold stable while `out_valid` = 1 and `out_ready` = 0.

## Timing
- Reset values: `in_ready` = 0 while `rstn` = 0, then 1 on the first cycle after release (IDLE). `out_valid` = 0, `out_max` = 0, `out_idx` = 0, `busy` = 0. State = IDLE and all internal registers = 0.
- Reset is asserted with priority in any state. A partially accumulated vector is discarded with no output.
- Throughput: the first element takes 1 cycle; each further element takes 2 cycles (RUN handshake, then WAIT).
- Latency with back-to-back input: first handshake at cycle 0, `out_valid` first high at cycle 2·`LEN`−1.
  - `LEN` = 1: `out_valid` at cycle 1.
- No element is accepted during WAIT or DONE. The next vector's first handshake can occur at the earliest on the cycle after the DONE→IDLE handshake.
- `in_ready` and `out_valid` are decoded from registered state only; there is no combinational path from `in_valid` or `out_ready`.

## Configuration
- **`SINGLE_ARGMAX_LAST_EN` defined**: a vector also ends on a handshake with `in_last` = 1, or at element `LEN`−1, whichever comes first.
  - `in_last` in IDLE goes directly to DONE.
  - `in_last` in RUN is registered with the candidate and ends the vector after WAIT.
- **Not defined**: `in_last` is ignored and every vector is exactly `LEN` elements.

## Test plan
- **Ascending vector**, `LEN`=4, input {BF800000, 00000000, 3F800000, 40000000} back-to-back → `out_max` = 40000000, `out_idx` = 3, `out_valid` rises at cycle 7.
- **Signed zero, max first**, `LEN`=4, input {40400000, C0000000, 80000000, 00000000} → `out_max` = 40400000, `out_idx` = 0. Checks +0 > −0 does not displace 3.0.
- **Ties**, `LEN`=4, input {3F800000, 40000000, 40000000, 3F800000} → `out_idx` = 1. Also `LEN`=1 with input {C0000000} → `out_max` = C0000000, `out_idx` = 0, `out_valid` at cycle 1.
- **Backpressure and stalls**: hold `out_ready` = 0 for 5 cycles → outputs stable and `in_ready` = 0 throughout. Insert 3 idle `in_valid` cycles mid-vector → same result as with no gaps.
- **Reset mid-vector**: pulse `rstn` = 0 after 2 of 4 elements → no `out_valid`. The next full vector {BF800000, C0000000, BF800000, C0400000} → `out_max` = BF800000, `out_idx` = 0.
- **Early end** (`SINGLE_ARGMAX_LAST_EN` defined), `LEN`=16, 3 elements {3F800000, 40400000, 40000000} with `in_last` on the third → `out_max` = 40400000, `out_idx` = 1.
